// File: rtl/gerador_movimento.sv
// Movement command generator feeding the bidirectional position counter:
// step-rate divider plus a 4-state manual/auto ping-pong controller.
module gerador_movimento #(
   parameter int unsigned DIV = 80,
   parameter int unsigned W   = 16,
   parameter int unsigned M   = 100,
   parameter int unsigned N   = 7
) (
   input  logic         clock,
   input  logic         zera_as_n,
   input  logic         iniciar,
   input  logic         parar,
   input  logic         modo_auto,
   input  logic         botao_vai,
   input  logic         botao_vem,
   input  logic [1:0]   velocidade,
   input  logic [N-1:0] pos,
   output logic         vai,
   output logic         vem,
   output logic         enable_mov,
   output logic         set_pos,
   output logic [N-1:0] D,
   output logic [1:0]   estado,
   output logic         ativo
);

   typedef enum logic [1:0] {
      PARADO   = 2'b00,
      MANUAL   = 2'b01,
      AUTO_VAI = 2'b10,
      AUTO_VEM = 2'b11
   } estado_t;

   localparam logic [N-1:0] CENTRO  = N'(M/2 - 1);
   localparam logic [N-1:0] POS_MAX = N'(M - 1);

   estado_t      estado_q, estado_nxt;
   logic         iniciar_d;
   logic         tick, tick_nxt;
   logic         set_pos_nxt;
   logic [W-1:0] cnt, cnt_nxt, limite;
   logic         ini_ed;

   assign ini_ed = iniciar & ~iniciar_d;
   assign D      = CENTRO;
   assign estado = estado_q;
   assign ativo  = (estado_q != PARADO);

   // Step period minus one for the selected speed
   always_comb begin
      limite = W'(DIV - 1);
      case (velocidade)
         2'd0: limite = W'(DIV - 1);
         2'd1: limite = W'(DIV/2 - 1);
         2'd2: limite = W'(DIV/4 - 1);
         2'd3: limite = W'(DIV/8 - 1);
      endcase
   end

   // State registers
   always_ff @(posedge clock or negedge zera_as_n) begin
      if (!zera_as_n) begin
         estado_q  <= PARADO;
         iniciar_d <= 1'b0;
         tick      <= 1'b0;
         cnt       <= '0;
         set_pos   <= 1'b0;
      end else begin
         estado_q  <= estado_nxt;
         iniciar_d <= iniciar;
         tick      <= tick_nxt;
         cnt       <= cnt_nxt;
         set_pos   <= set_pos_nxt;
      end
   end

   // Next state and movement outputs; stop overrides everything
   always_comb begin
      estado_nxt  = estado_q;
      set_pos_nxt = 1'b0;
      vai         = 1'b0;
      vem         = 1'b0;
      enable_mov  = 1'b0;
      case (estado_q)
         PARADO: begin
            if (ini_ed) begin
               estado_nxt  = modo_auto ? AUTO_VAI : MANUAL;
               set_pos_nxt = 1'b1;
            end
         end
         MANUAL: begin
            vai        = botao_vai & ~botao_vem;
            vem        = botao_vem & ~botao_vai;
            enable_mov = tick & (vai | vem);
         end
         AUTO_VAI: begin
            vai = 1'b1;
            if (pos == POS_MAX) estado_nxt = AUTO_VEM;
            else                enable_mov = tick;
         end
         AUTO_VEM: begin
            vem = 1'b1;
            if (pos == '0) estado_nxt = AUTO_VAI;
            else           enable_mov = tick;
         end
      endcase
      if (parar) begin
         estado_nxt  = PARADO;
         set_pos_nxt = 1'b0;
         enable_mov  = 1'b0;
      end
   end

   // Step-rate divider; an over-limit count after a speed change clears silently
   always_comb begin
      cnt_nxt  = '0;
      tick_nxt = 1'b0;
      if (estado_q != PARADO && !parar) begin
         if (cnt == limite) begin
            tick_nxt = 1'b1;
         end else if (cnt < limite) begin
            cnt_nxt = cnt + W'(1);
         end
      end
   end

endmodule
